// File: rtl/axi_master_wr.sv
// Command-driven AXI4 write master: splits each (address, beat count) command into 4 KB-safe INCR bursts.
// Optional build macro AXI_MASTER_WR_TLAST_CHECK_EN enables the data-stream tlast consistency check (status bit 19).
module axi_master_wr #(
  parameter int AXI_DWIDTH  = 128,
  parameter int AXI_AWIDTH  = 32,
  parameter int AXI_IDWIDTH = 1,
  parameter int MAX_BURST   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [AXI_IDWIDTH-1:0]   m_axi_awid,
  output logic [AXI_AWIDTH-1:0]    m_axi_awaddr,
  output logic [7:0]               m_axi_awlen,
  output logic [2:0]               m_axi_awsize,
  output logic [1:0]               m_axi_awburst,
  output logic                     m_axi_awlock,
  output logic [3:0]               m_axi_awcache,
  output logic [2:0]               m_axi_awprot,
  output logic [3:0]               m_axi_awregion,
  output logic [3:0]               m_axi_awqos,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [AXI_DWIDTH-1:0]    m_axi_wdata,
  output logic [AXI_DWIDTH/8-1:0]  m_axi_wstrb,
  output logic                     m_axi_wlast,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [AXI_IDWIDTH-1:0]   m_axi_bid,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  input  logic                     s_axis_cmd_tvalid,
  output logic                     s_axis_cmd_tready,
  input  logic [47:0]              s_axis_cmd_tdata,
  input  logic [AXI_DWIDTH-1:0]    s_axis_data_tdata,
  input  logic                     s_axis_data_tvalid,
  input  logic                     s_axis_data_tlast,
  output logic                     s_axis_data_tready,
  output logic                     m_axis_status_tvalid,
  input  logic                     m_axis_status_tready,
  output logic [31:0]              m_axis_status_tdata,
  output logic                     m_axis_status_tlast
);

  generate
    if (AXI_DWIDTH != 128) begin : g_bad_dwidth
      $error("axi_master_wr: AXI_DWIDTH must be 128");
    end
    if (AXI_AWIDTH != 32) begin : g_bad_awidth
      $error("axi_master_wr: AXI_AWIDTH must be 32");
    end
    if ((MAX_BURST < 1) || (MAX_BURST > 256) || ((MAX_BURST & (MAX_BURST - 1)) != 0)) begin : g_bad_burst
      $error("axi_master_wr: MAX_BURST must be a power of two in 1..256");
    end
  endgenerate

  localparam logic [16:0] MAX_BURST_L = 17'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AW     = 3'd1,
    S_W      = 3'd2,
    S_B      = 3'd3,
    S_STATUS = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] addr_r;
  logic [15:0] remaining_r;
  logic [15:0] beats_r;
  logic [8:0]  burst_len_r;
  logic [8:0]  beat_cnt_r;
  logic [1:0]  resp_r;
  logic        err_r;
  logic        tlast_err_r;

  logic        cmd_hs_s, w_hs_s, wlast_s, tlast_bad_s;
  logic [8:0]  room_s, len_s;
  logic [16:0] lim_s;

  // Beats left before the 4 KB page ends (1..256); burst length is the tightest of three limits.
  assign room_s = 9'd256 - {1'b0, addr_r[11:4]};
  assign lim_s  = ({1'b0, remaining_r} < MAX_BURST_L) ? {1'b0, remaining_r} : MAX_BURST_L;
  assign len_s  = (lim_s < {8'd0, room_s}) ? lim_s[8:0] : room_s;

  assign cmd_hs_s = s_axis_cmd_tvalid & s_axis_cmd_tready;
  assign w_hs_s   = m_axi_wvalid & m_axi_wready;
  assign wlast_s  = (beat_cnt_r == (burst_len_r - 9'd1));

`ifdef AXI_MASTER_WR_TLAST_CHECK_EN
  assign tlast_bad_s = s_axis_data_tlast != (wlast_s && (remaining_r == {7'd0, burst_len_r}));
`else
  assign tlast_bad_s = 1'b0;
  logic unused_tlast;
  assign unused_tlast = s_axis_data_tlast;
`endif

  logic unused_in;
  assign unused_in = ^{m_axi_bid, s_axis_cmd_tdata[3:0]};

  assign m_axi_awid     = {AXI_IDWIDTH{1'b0}};
  assign m_axi_awaddr   = addr_r;
  assign m_axi_awlen    = 8'(len_s - 9'd1);
  assign m_axi_awsize   = 3'b100;
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'b0011;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awregion = 4'b0000;
  assign m_axi_awqos    = 4'b0000;
  assign m_axi_awvalid  = (state_r == S_AW);

  assign m_axi_wdata        = s_axis_data_tdata;
  assign m_axi_wstrb        = {(AXI_DWIDTH/8){1'b1}};
  assign m_axi_wlast        = wlast_s;
  assign m_axi_wvalid       = (state_r == S_W) & s_axis_data_tvalid;
  assign s_axis_data_tready = (state_r == S_W) & m_axi_wready;
  assign m_axi_bready       = (state_r == S_B);

  // Gated by rst so the command port reports not-ready while reset is held.
  assign s_axis_cmd_tready    = (state_r == S_IDLE) & ~rst;
  assign m_axis_status_tvalid = (state_r == S_STATUS);
  assign m_axis_status_tlast  = (state_r == S_STATUS);
  assign m_axis_status_tdata  = {12'd0, tlast_err_r, err_r, resp_r, beats_r};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_hs_s) begin
          state_s = (s_axis_cmd_tdata[47:32] == 16'd0) ? S_STATUS : S_AW;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_AW: begin
        if (m_axi_awready) state_s = S_W;
        else               state_s = S_AW;
      end
      S_W: begin
        if (w_hs_s && wlast_s) state_s = S_B;
        else                   state_s = S_W;
      end
      S_B: begin
        if (m_axi_bvalid) state_s = (remaining_r != 16'd0) ? S_AW : S_STATUS;
        else              state_s = S_B;
      end
      S_STATUS: begin
        if (m_axis_status_tready) state_s = S_IDLE;
        else                      state_s = S_STATUS;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Command, burst and status bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r      <= 32'd0;
      remaining_r <= 16'd0;
      beats_r     <= 16'd0;
      burst_len_r <= 9'd0;
      beat_cnt_r  <= 9'd0;
      resp_r      <= 2'b00;
      err_r       <= 1'b0;
      tlast_err_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cmd_hs_s) begin
            addr_r      <= {s_axis_cmd_tdata[31:4], 4'b0000};
            remaining_r <= s_axis_cmd_tdata[47:32];
            beats_r     <= 16'd0;
            resp_r      <= 2'b00;
            err_r       <= 1'b0;
            tlast_err_r <= 1'b0;
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            burst_len_r <= len_s;
            beat_cnt_r  <= 9'd0;
          end
        end
        S_W: begin
          if (w_hs_s) begin
            beat_cnt_r <= beat_cnt_r + 9'd1;
            beats_r    <= beats_r + 16'd1;
            if (tlast_bad_s) tlast_err_r <= 1'b1;
            if (wlast_s) begin
              addr_r      <= addr_r + {19'd0, burst_len_r, 4'b0000};
              remaining_r <= remaining_r - {7'd0, burst_len_r};
            end
          end
        end
        S_B: begin
          // Only the first error response is kept; later ones leave it untouched.
          if (m_axi_bvalid && (m_axi_bresp != 2'b00) && !err_r) begin
            resp_r <= m_axi_bresp;
            err_r  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_wr.sv
// Self-checking bench for axi_master_wr: random slave/source backpressure, burst-split reference model.
module tb_axi_master_wr;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [0:0]    m_axi_awid;
  logic [31:0]   m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awlock;
  logic [3:0]    m_axi_awcache;
  logic [2:0]    m_axi_awprot;
  logic [3:0]    m_axi_awregion;
  logic [3:0]    m_axi_awqos;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [127:0]  m_axi_wdata;
  logic [15:0]   m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [0:0]    m_axi_bid;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic          s_axis_cmd_tvalid;
  logic          s_axis_cmd_tready;
  logic [47:0]   s_axis_cmd_tdata;
  logic [127:0]  s_axis_data_tdata;
  logic          s_axis_data_tvalid;
  logic          s_axis_data_tlast;
  logic          s_axis_data_tready;
  logic          m_axis_status_tvalid;
  logic          m_axis_status_tready;
  logic [31:0]   m_axis_status_tdata;
  logic          m_axis_status_tlast;

  axi_master_wr dut (
    .clk(clk), .rst(rst),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awregion(m_axi_awregion),
    .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .s_axis_cmd_tvalid(s_axis_cmd_tvalid), .s_axis_cmd_tready(s_axis_cmd_tready),
    .s_axis_cmd_tdata(s_axis_cmd_tdata),
    .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tlast(s_axis_data_tlast), .s_axis_data_tready(s_axis_data_tready),
    .m_axis_status_tvalid(m_axis_status_tvalid), .m_axis_status_tready(m_axis_status_tready),
    .m_axis_status_tdata(m_axis_status_tdata), .m_axis_status_tlast(m_axis_status_tlast)
  );

  int errors = 0;
  int checks = 0;
  int bp = 0;

  // Source data and slave response configuration, filled by the main sequence.
  logic [127:0] src_data[$];
  bit           src_last[$];
  logic [1:0]   resp_cfg[int];

  // Observed traffic, recorded by the monitor.
  logic [31:0]  aw_addr_q[$];
  logic [7:0]   aw_len_q[$];
  logic [127:0] w_data_q[$];
  bit           w_last_q[$];
  int aw_cnt = 0, wlast_cnt = 0, b_cnt = 0, s_cnt = 0, order_err = 0;
  int src_cur = -1, b_cur = -1;

  function automatic bit go();
    return (bp == 0) || ($urandom_range(99, 0) >= bp);
  endfunction

  // Monitor: handshakes are recorded at the clock edge where they complete.
  always @(posedge clk) begin
    if (!rst) begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_addr_q.push_back(m_axi_awaddr);
        aw_len_q.push_back(m_axi_awlen);
        aw_cnt++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (aw_cnt <= wlast_cnt) order_err++;
        w_data_q.push_back(m_axi_wdata);
        w_last_q.push_back(m_axi_wlast);
        if (m_axi_wlast) wlast_cnt++;
      end
      if (s_axis_data_tvalid && s_axis_data_tready) s_cnt++;
      if (m_axi_bvalid && m_axi_bready) b_cnt++;
    end
  end

  // Data source: AXI-Stream compliant (tvalid held until accepted).
  always @(negedge clk) begin
    if (rst) begin
      s_axis_data_tvalid = 1'b0;
      s_axis_data_tlast  = 1'b0;
      s_axis_data_tdata  = 128'd0;
      src_cur            = -1;
    end else if (!(s_axis_data_tvalid && src_cur == s_cnt)) begin
      if (s_cnt < src_data.size() && go()) begin
        s_axis_data_tvalid = 1'b1;
        s_axis_data_tdata  = src_data[s_cnt];
        s_axis_data_tlast  = src_last[s_cnt];
        src_cur            = s_cnt;
      end else begin
        s_axis_data_tvalid = 1'b0;
      end
    end
  end

  // Slave: random ready, one B response per completed burst.
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      b_cur         = -1;
    end else begin
      m_axi_awready = go();
      m_axi_wready  = go();
      if (!(m_axi_bvalid && b_cur == b_cnt)) begin
        if (wlast_cnt > b_cnt && go()) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = resp_cfg.exists(b_cnt) ? resp_cfg[b_cnt] : 2'b00;
          b_cur        = b_cnt;
        end else begin
          m_axi_bvalid = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int cnt, input int bp_in, input int hold,
                         input int tlast_pos, input int err_burst, input logic [1:0] err_code,
                         input bit lat);
    logic [31:0]  exp_a[$];
    logic [7:0]   exp_l[$];
    bit           exp_last[$];
    logic [127:0] exp_d[$];
    logic [31:0]  a;
    logic [31:0]  exp_status;
    logic [1:0]   first;
    bit           err, tl_bad;
    int rem, room, len, t, bad, aw0, w0, b0;

    aw0 = aw_addr_q.size();
    w0  = w_data_q.size();
    b0  = b_cnt;
    // Reference burst split: page-bounded, MAXB-bounded INCR bursts of 16-byte beats.
    a   = {addr[31:4], 4'b0000};
    rem = cnt;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 16;
      len  = rem;
      if (len > MAXB) len = MAXB;
      if (len > room) len = room;
      exp_a.push_back(a);
      exp_l.push_back(8'(len - 1));
      for (int j = 0; j < len; j++) exp_last.push_back(j == len - 1);
      a   = a + 32'(16 * len);
      rem = rem - len;
    end
    first = 2'b00;
    err   = 1'b0;
    if (err_burst >= 0 && err_burst < exp_a.size() && err_code != 2'b00) begin
      resp_cfg[b0 + err_burst] = err_code;
      first = err_code;
      err   = 1'b1;
    end
    tl_bad = 1'b0;
`ifdef AXI_MASTER_WR_TLAST_CHECK_EN
    tl_bad = (tlast_pos >= 0) && (tlast_pos != cnt - 1);
`endif
    exp_status = {12'd0, tl_bad, err, first, 16'(cnt)};
    for (int i = 0; i < cnt; i++) begin
      logic [127:0] d;
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_d.push_back(d);
      src_data.push_back(d);
      src_last.push_back((tlast_pos < 0) ? (i == cnt - 1) : (i == tlast_pos));
    end
    bp = bp_in;

    t = 0;
    while (!s_axis_cmd_tready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_timeout", 128'(t < 1000), 128'(1));
    s_axis_cmd_tvalid = 1'b1;
    s_axis_cmd_tdata  = {16'(cnt), addr};
    @(posedge clk);
    #1;
    s_axis_cmd_tvalid = 1'b0;
    if (lat) begin
      if (cnt == 0) begin
        chk("zero_status_lat", 128'(m_axis_status_tvalid), 128'(1));
        chk("zero_no_aw", 128'(m_axi_awvalid), 128'(0));
      end else begin
        chk("aw_lat", 128'(m_axi_awvalid), 128'(1));
        chk("aw_addr0", 128'(m_axi_awaddr), 128'(exp_a[0]));
      end
    end

    t = 0;
    while (!m_axis_status_tvalid && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("status_timeout", 128'(t < 5000), 128'(1));
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!(m_axis_status_tvalid === 1'b1 && m_axis_status_tdata === exp_status)) bad++;
    end
    chk("status_hold", 128'(bad), 128'(0));
    chk("status_data", 128'(m_axis_status_tdata), 128'(exp_status));
    chk("status_tlast", 128'(m_axis_status_tlast), 128'(1));
    m_axis_status_tready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_status_tready = 1'b0;
    chk("status_drop", 128'(m_axis_status_tvalid), 128'(0));
    chk("cmd_ready_back", 128'(s_axis_cmd_tready), 128'(1));

    chk("aw_count", 128'(aw_addr_q.size() - aw0), 128'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && aw0 + i < aw_addr_q.size(); i++) begin
      chk("aw_addr", 128'(aw_addr_q[aw0 + i]), 128'(exp_a[i]));
      chk("aw_len", 128'(aw_len_q[aw0 + i]), 128'(exp_l[i]));
    end
    chk("b_count", 128'(b_cnt - b0), 128'(exp_a.size()));
    chk("w_count", 128'(w_data_q.size() - w0), 128'(cnt));
    for (int i = 0; i < cnt && w0 + i < w_data_q.size(); i++) begin
      chk("w_data", w_data_q[w0 + i], exp_d[i]);
      chk("w_last", 128'(w_last_q[w0 + i]), 128'(exp_last[i]));
    end
    bp = 0;
  endtask

  initial begin
    rst                  = 1'b1;
    s_axis_cmd_tvalid    = 1'b0;
    s_axis_cmd_tdata     = 48'd0;
    m_axis_status_tready = 1'b0;
    m_axi_bid            = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_data_tready,
                            s_axis_cmd_tready, m_axis_status_tvalid}), 128'(0));
    chk("rst_status_data", 128'(m_axis_status_tdata), 128'(0));
    rst = 1'b0;
    #1;
    chk("cmd_ready_after_rst", 128'(s_axis_cmd_tready), 128'(1));

    run_cmd(32'h1000_0000, 16, 0, 0, -1, -1, 2'b00, 1'b1);
    run_cmd(32'h0000_0F80, 40, 0, 0, -1, -1, 2'b00, 1'b1);
    run_cmd(32'h0000_0000, 0, 0, 2, -1, -1, 2'b00, 1'b1);
    run_cmd(32'h0000_2000, 32, 0, 0, -1, 1, 2'b10, 1'b0);
    run_cmd(32'h3000_0008, 37, 50, 10, -1, -1, 2'b00, 1'b0);
    run_cmd(32'h0000_0FFC, 3, 0, 0, -1, 0, 2'b11, 1'b1);
    run_cmd(32'h0000_4000, 8, 30, 0, 4, -1, 2'b00, 1'b0);

    // Constant AW/W fields while a burst address is being presented.
    s_axis_cmd_tvalid = 1'b1;
    s_axis_cmd_tdata  = {16'd4, 32'h0000_5000};
    @(posedge clk);
    #1;
    s_axis_cmd_tvalid = 1'b0;
    chk("aw_const", 128'({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache,
                          m_axi_awprot, m_axi_awregion, m_axi_awqos}),
        128'({1'b0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 4'b0000}));
    chk("wstrb", 128'(m_axi_wstrb), 128'(16'hFFFF));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_burst", 128'({m_axi_awvalid, m_axi_wvalid, m_axis_status_tvalid}), 128'(0));
    rst = 1'b0;

    for (int r = 0; r < 4; r++) begin
      run_cmd($urandom(), $urandom_range(100, 1), r * 20, $urandom_range(3, 0), -1,
              $urandom_range(3, 0) - 1, 2'($urandom_range(3, 1)), 1'b0);
    end

    chk("w_before_aw", 128'(order_err), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
